// File: rtl/fdiv_issue_ctrl.sv
// Issue/collect front end for a fixed-latency, non-stallable FP32 divider.
// Latency: accept -> result visible at the FIFO head LATENCY edges later.
// Backpressure: out_ready stalls the FIFO; occupancy credits then close in_ready.

// In-order first-word-fall-through result buffer with circular pointers.
// Latency: a write is visible at the head on the following cycle.
// Backpressure: rd_rdy pops the head; writes are only accepted while not full.
module fdiv_res_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;
  assign rd_vld = !empty;
  assign rd_dat = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module fdiv_issue_ctrl #(
  parameter int LATENCY = 7,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_x1,
  output logic [31:0]      div_x2,
  input  logic [31:0]      div_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz,
  output logic             idle
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } res_t;

  logic [OCC_W-1:0]   occ;
  logic               accept;
  logic               pop;
  logic [LATENCY-1:0] pipe_vld;
  logic [LATENCY-1:0] pipe_dz;
  logic [TAG_W-1:0]   pipe_tag [LATENCY];
  res_t               wr_dat;
  res_t               rd_dat;

  assign div_x1   = in_x1;
  assign div_x2   = in_x2;
  assign in_ready = !rst && (occ < OCC_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign idle     = (occ == '0);

  // Every accepted op holds a FIFO slot from issue until pop, so the
  // divider can never deliver into a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld <= {pipe_vld[LATENCY-2:0], accept};
    end
  end

  // Sideband only matters where the matching valid bit is set.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= in_tag;
    pipe_dz     <= {pipe_dz[LATENCY-2:0], (in_x2[30:23] == 8'h00)};
    for (int i = 1; i < LATENCY; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  assign wr_dat.y   = div_y;
  assign wr_dat.tag = pipe_tag[LATENCY-1];
  assign wr_dat.dz  = pipe_dz[LATENCY-1];

  fdiv_res_fifo #(
    .W     ($bits(res_t)),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (pipe_vld[LATENCY-1]),
    .wr_dat (wr_dat),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (rd_dat)
  );

  assign out_y   = rd_dat.y;
  assign out_tag = rd_dat.tag;
  assign out_dz  = rd_dat.dz;
endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Directed bench for fdiv_issue_ctrl with a pipelined divider model and an in-order scoreboard.
module tb_fdiv_issue_ctrl;
  localparam int L = 7;
  localparam int D = 4;

  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  tag;
    logic        dz;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x1;
  logic [31:0] in_x2;
  logic [3:0]  in_tag;
  logic [31:0] div_x1;
  logic [31:0] div_x2;
  logic [31:0] div_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_tag;
  logic        out_dz;
  logic        idle;

  int   errors;
  int   checks;
  exp_t sb [$];
  logic [31:0] dpipe [L];

  fdiv_issue_ctrl #(.LATENCY(L), .DEPTH(D), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .div_x1(div_x1), .div_x2(div_x2), .div_y(div_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_tag(out_tag), .out_dz(out_dz), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known quotients for the directed operands; anything else maps to an
  // operand-dependent pattern so misaligned captures are visible.
  function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h3F000000;
      {32'h40C00000, 32'h40400000}: return 32'h40000000;
      {32'h41000000, 32'h40000000}: return 32'h40800000;
      {32'h41100000, 32'h40400000}: return 32'h40400000;
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
      default: begin
        if (b[30:0] == 31'h0) return {a[31] ^ b[31], 8'hFF, 23'h0};
        return (a ^ {b[15:0], b[31:16]}) + 32'h01234567;
      end
    endcase
  endfunction

  initial begin
    for (int i = 0; i < L; i++) dpipe[i] = 32'h0;
  end

  always @(posedge clk) begin
    dpipe[0] <= fake_div(div_x1, div_x2);
    for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_y = dpipe[L-1];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on consumer handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", 32'(out_valid), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_y", out_y, e.y);
          check("sb_tag", 32'(out_tag), 32'(e.tag));
          check("sb_dz", 32'(out_dz), 32'(e.dz));
        end
      end
      if (in_valid && in_ready)
        sb.push_back('{fake_div(in_x1, in_x2), in_tag, (in_x2[30:23] == 8'h00)});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input int maxc, input string name);
    int n = 0;
    while (!out_valid && n < maxc) begin
      step(1);
      n++;
    end
    check(name, 32'(out_valid), 32'h1);
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n = 0;
    while (!idle && n < maxc) begin
      step(1);
      n++;
    end
    check(name, 32'(idle), 32'h1);
  endtask

  task automatic drive(input logic [31:0] x1, input logic [31:0] x2, input logic [3:0] tag);
    in_valid = 1'b1;
    in_x1    = x1;
    in_x2    = x2;
    in_tag   = tag;
  endtask

  initial begin
    int n;
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x1     = 32'h0;
    in_x2     = 32'h0;
    in_tag    = 4'h0;
    out_ready = 1'b0;

    // Reset state
    step(3);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_idle", 32'(idle), 32'h1);
    check("rst_out_y", out_y, 32'h0);
    check("rst_out_tag", 32'(out_tag), 32'h0);
    check("rst_out_dz", 32'(out_dz), 32'h0);
    rst = 1'b0;
    step(1);
    check("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Single op: 1.0 / 2.0, tag 3
    drive(32'h3F800000, 32'h40000000, 4'd3);
    check("div_x2_passthru", div_x2, 32'h40000000);
    step(1);
    in_valid = 1'b0;
    check("single_busy", 32'(idle), 32'h0);
    step(L - 1);
    check("single_not_early", 32'(out_valid), 32'h0);
    step(1);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_y", out_y, 32'h3F000000);
    check("single_tag", 32'(out_tag), 32'h3);
    check("single_dz", 32'(out_dz), 32'h0);
    out_ready = 1'b1;
    step(1);
    check("single_popped", 32'(out_valid), 32'h0);
    check("single_idle", 32'(idle), 32'h1);

    // Back-to-back, consumer always ready
    drive(32'h40C00000, 32'h40400000, 4'd0); step(1);
    drive(32'h41000000, 32'h40000000, 4'd1); step(1);
    drive(32'h41100000, 32'h40400000, 4'd2); step(1);
    drive(32'h3F800000, 32'h3F800000, 4'd3); step(1);
    in_valid = 1'b0;
    check("b2b_full_in_ready", 32'(in_ready), 32'h0);
    wait_out_valid(L + 2, "b2b_first_valid");
    check("b2b_still_full", 32'(in_ready), 32'h0);
    check("b2b_first_tag", 32'(out_tag), 32'h0);
    step(1);
    check("b2b_ready_after_pop", 32'(in_ready), 32'h1);
    check("b2b_next_valid", 32'(out_valid), 32'h1);
    step(1);
    check("b2b_third_valid", 32'(out_valid), 32'h1);
    wait_idle(L + 8, "b2b_drained");

    // Backpressure: fill to DEPTH, then drain in order
    out_ready = 1'b0;
    n = 0;
    while (in_ready && n < 20) begin
      drive($urandom, $urandom, 4'($urandom_range(0, 15)));
      step(1);
      n++;
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(n), 32'(D));
    step(L + 2);
    check("bp_in_ready_low", 32'(in_ready), 32'h0);
    check("bp_out_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    wait_idle(D + 4, "bp_drained");
    check("bp_sb_empty", 32'(sb.size()), 32'h0);

    // Simultaneous accept and pop with occ=2 (A buffered, B arriving)
    out_ready = 1'b0;
    drive(32'h12345678, 32'h3F000001, 4'd10); step(1);
    drive(32'h87654321, 32'h40100000, 4'd11); step(1);
    in_valid = 1'b0;
    wait_out_valid(L + 2, "sim_a_valid");
    check("sim_a_tag", 32'(out_tag), 32'd10);
    drive(32'h0BADF00D, 32'h41200000, 4'd12);
    out_ready = 1'b1;
    step(1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("sim_in_ready", 32'(in_ready), 32'h1);
    check("sim_busy", 32'(idle), 32'h0);
    check("sim_b_head", 32'(out_valid), 32'h1);
    check("sim_b_tag", 32'(out_tag), 32'd11);
    check("sim_b_y", out_y, fake_div(32'h87654321, 32'h40100000));
    out_ready = 1'b1;
    wait_idle(L + 6, "sim_drained");

    // Divide by zero: result passes through, dz flagged
    drive(32'h3F800000, 32'h00000000, 4'd5);
    out_ready = 1'b0;
    step(1);
    in_valid = 1'b0;
    wait_out_valid(L + 2, "dz_valid");
    check("dz_flag", 32'(out_dz), 32'h1);
    check("dz_y", out_y, 32'h7F800000);
    check("dz_tag", 32'(out_tag), 32'h5);
    out_ready = 1'b1;
    wait_idle(4, "dz_drained");

    // Reset mid-flight
    drive(32'h11111111, 32'h40400000, 4'd6); step(1);
    drive(32'h22222222, 32'h40800000, 4'd7); step(1);
    drive(32'h33333333, 32'h40A00000, 4'd8); step(1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    step(1);
    rst = 1'b0;
    for (int i = 0; i < L + 2; i++) begin
      step(1);
      check("midrst_no_valid", 32'(out_valid), 32'h0);
      check("midrst_idle", 32'(idle), 32'h1);
    end
    drive(32'h3F800000, 32'h40000000, 4'd9);
    step(1);
    in_valid = 1'b0;
    wait_out_valid(L + 2, "midrst_new_valid");
    check("midrst_new_tag", 32'(out_tag), 32'h9);
    wait_idle(4, "midrst_new_drained");
    check("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
